// File: rtl/instr_fetch.sv
// Instruction fetch: reads pc, fetches from imem via req/ack, buffers for decode.
// Drives pc_next (hold, +4 or redirect) back to the PC register every cycle.
module instr_fetch #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, FAULT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t          state, state_nx;
    logic            req_nx, valid_nx, fault_nx, kill, kill_nx;
    logic [XLEN-1:0] addr_nx, instr_nx, ipc_nx;
    logic [7:0]      wait_cnt, wait_cnt_nx;

    always_comb begin
        pc_next = pc;
        if (state == FAULT)
            pc_next = pc;
        else if (redirect)
            pc_next = redirect_target;
        else if (state == WAIT && imem_ack && !kill)
            pc_next = imem_addr + XLEN'(4);
    end

    always_comb begin
        state_nx    = state;
        req_nx      = imem_req;
        addr_nx     = imem_addr;
        valid_nx    = instr_valid;
        instr_nx    = instr;
        ipc_nx      = instr_pc;
        fault_nx    = fetch_fault;
        kill_nx     = kill;
        wait_cnt_nx = wait_cnt;
        unique case (state)
            IDLE: begin
                if (pc[1:0] != 2'b00) begin
                    fault_nx = 1'b1;
                    state_nx = FAULT;
                end else if (!redirect) begin
                    req_nx      = 1'b1;
                    addr_nx     = pc;
                    wait_cnt_nx = '0;
                    state_nx    = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    req_nx = 1'b0;
                    if (kill || redirect) begin
                        // Wrong-path data: the request completes but is dropped.
                        kill_nx  = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        instr_nx = imem_rdata;
                        ipc_nx   = imem_addr;
                        valid_nx = 1'b1;
                        state_nx = HOLD;
                    end
                end else begin
                    if (redirect)
                        kill_nx = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        req_nx   = 1'b0;
                        fault_nx = 1'b1;
                        state_nx = FAULT;
                    end else begin
                        wait_cnt_nx = wait_cnt + 8'd1;
                    end
                end
            end
            HOLD: begin
                if (instr_ready || redirect) begin
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            FAULT: begin
                state_nx = FAULT;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_fault <= 1'b0;
            kill        <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_nx;
            imem_req    <= req_nx;
            imem_addr   <= addr_nx;
            instr_valid <= valid_nx;
            instr       <= instr_nx;
            instr_pc    <= ipc_nx;
            fetch_fault <= fault_nx;
            kill        <= kill_nx;
            wait_cnt    <= wait_cnt_nx;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table for fetch/redirect flows,
// hand sequences for timeout, misalignment and reset corners.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // PC register on the other side of the pc/pc_next interface
    always_ff @(posedge clk)
        pc <= reset ? 32'h0 : pc_next;

    instr_fetch #(.XLEN(32), .MAX_WAIT(15)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pc_next        (pc_next),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic [31:0] pcn;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(logic redir, logic [31:0] tgt, logic ack,
                               logic [31:0] rdata, logic rdy, logic req,
                               logic [31:0] addr, logic vld, logic [31:0] ins,
                               logic [31:0] ipc, logic [31:0] pcn);
        vec_t r;
        r.redir = redir; r.tgt = tgt; r.ack = ack; r.rdata = rdata;
        r.rdy = rdy; r.req = req; r.addr = addr; r.vld = vld;
        r.ins = ins; r.ipc = ipc; r.pcn = pcn;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Apply one cycle of inputs after the falling edge, settle, then sample.
    task automatic step(logic rst, logic redir, logic [31:0] tgt, logic ack,
                        logic [31:0] rdata, logic rdy);
        @(negedge clk);
        reset = rst; redirect = redir; redirect_target = tgt;
        imem_ack = ack; imem_rdata = rdata; instr_ready = rdy;
        #1;
    endtask

    localparam logic [31:0] I1 = 32'h00500093;
    localparam logic [31:0] I2 = 32'h22222222;
    localparam logic [31:0] I3 = 32'h33333333;
    localparam logic [31:0] NP = 32'hFFFFFFFC;

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_target = '0;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);

        // fetch at 0, ack on third WAIT cycle
        tv.push_back(v(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 1, I1, 0,  1, 0, 0, 0, 0, 4));
        // decode stalls 5 cycles, then accepts
        for (int i = 0; i < 5; i++)
            tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, I1, 0, 4));
        tv.push_back(v(0, 0, 0, 0, 1,   0, 0, 1, I1, 0, 4));
        tv.push_back(v(0, 0, 0, 0, 0,   0, 0, 0, I1, 0, 4));
        // redirect in WAIT, late ack is dropped
        tv.push_back(v(1, 32'h100, 0, 0, 0, 1, 4, 0, I1, 0, 32'h100));
        tv.push_back(v(0, 0, 0, 0, 0,   1, 4, 0, I1, 0, 32'h100));
        tv.push_back(v(0, 0, 0, 0, 0,   1, 4, 0, I1, 0, 32'h100));
        tv.push_back(v(0, 0, 1, 32'hDEADBEEF, 0, 1, 4, 0, I1, 0, 32'h100));
        tv.push_back(v(0, 0, 0, 0, 0,   0, 4, 0, I1, 0, 32'h100));
        tv.push_back(v(0, 0, 1, 32'h13, 0, 1, 32'h100, 0, I1, 0, 32'h104));
        // redirect with ready in HOLD, then redirect in IDLE
        tv.push_back(v(1, 32'h200, 0, 0, 1,
                       0, 32'h100, 1, 32'h13, 32'h100, 32'h200));
        tv.push_back(v(1, 32'h300, 0, 0, 0,
                       0, 32'h100, 0, 32'h13, 32'h100, 32'h300));
        tv.push_back(v(0, 0, 0, 0, 0,
                       0, 32'h100, 0, 32'h13, 32'h100, 32'h300));
        // redirect and ack in the same cycle
        tv.push_back(v(1, 32'h400, 1, 32'h11111111, 0,
                       1, 32'h300, 0, 32'h13, 32'h100, 32'h400));
        tv.push_back(v(0, 0, 0, 0, 0,
                       0, 32'h300, 0, 32'h13, 32'h100, 32'h400));
        tv.push_back(v(0, 0, 1, I2, 0,
                       1, 32'h400, 0, 32'h13, 32'h100, 32'h404));
        tv.push_back(v(0, 0, 0, 0, 1,
                       0, 32'h400, 1, I2, 32'h400, 32'h404));
        // top of address space: +4 wraps to 0
        tv.push_back(v(1, NP, 0, 0, 0,  0, 32'h400, 0, I2, 32'h400, NP));
        tv.push_back(v(0, 0, 0, 0, 0,   0, 32'h400, 0, I2, 32'h400, NP));
        tv.push_back(v(0, 0, 1, I3, 0,  1, NP, 0, I2, 32'h400, 0));
        tv.push_back(v(0, 0, 0, 0, 1,   0, NP, 1, I3, NP, 0));
        tv.push_back(v(0, 0, 0, 0, 0,   0, NP, 0, I3, NP, 0));

        foreach (tv[i]) begin
            step(0, tv[i].redir, tv[i].tgt, tv[i].ack, tv[i].rdata, tv[i].rdy);
            chk($sformatf("r%0d req", i), 32'(imem_req), 32'(tv[i].req));
            chk($sformatf("r%0d addr", i), imem_addr, tv[i].addr);
            chk($sformatf("r%0d valid", i), 32'(instr_valid), 32'(tv[i].vld));
            chk($sformatf("r%0d instr", i), instr, tv[i].ins);
            chk($sformatf("r%0d instr_pc", i), instr_pc, tv[i].ipc);
            chk($sformatf("r%0d fault", i), 32'(fetch_fault), 32'h0);
            chk($sformatf("r%0d pc_next", i), pc_next, tv[i].pcn);
        end

        // timeout: request at 0 now pending, never acked
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk($sformatf("to%0d req", i), 32'(imem_req), 32'h1);
            chk($sformatf("to%0d fault", i), 32'(fetch_fault), 32'h0);
        end
        step(0, 0, 0, 0, 0, 0);
        chk("to fault", 32'(fetch_fault), 32'h1);
        chk("to req", 32'(imem_req), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h40, (i == 1), 32'h55, 1);
            chk($sformatf("flt%0d fault", i), 32'(fetch_fault), 32'h1);
            chk($sformatf("flt%0d req", i), 32'(imem_req), 32'h0);
            chk($sformatf("flt%0d valid", i), 32'(instr_valid), 32'h0);
            chk($sformatf("flt%0d pc_next", i), pc_next, 32'h0);
        end

        // misaligned redirect target
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'h102, 0, 0, 0);
        chk("rst fault", 32'(fetch_fault), 32'h0);
        chk("rst req", 32'(imem_req), 32'h0);
        chk("rst instr", instr, 32'h0);
        chk("rst instr_pc", instr_pc, 32'h0);
        chk("rst addr", imem_addr, 32'h0);
        chk("mis pc_next", pc_next, 32'h102);
        step(0, 0, 0, 0, 0, 0);
        chk("mis idle req", 32'(imem_req), 32'h0);
        chk("mis idle fault", 32'(fetch_fault), 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk($sformatf("mis%0d fault", i), 32'(fetch_fault), 32'h1);
            chk($sformatf("mis%0d req", i), 32'(imem_req), 32'h0);
            chk($sformatf("mis%0d pc_next", i), pc_next, 32'h102);
        end

        // reset in HOLD, then reset in WAIT
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hAAAA5555, 0);
        chk("h ack req", 32'(imem_req), 32'h1);
        chk("h ack pc_next", pc_next, 32'h4);
        step(1, 0, 0, 0, 0, 0);
        chk("h valid", 32'(instr_valid), 32'h1);
        chk("h instr", instr, 32'hAAAA5555);
        step(0, 0, 0, 0, 0, 0);
        chk("hr valid", 32'(instr_valid), 32'h0);
        chk("hr instr", instr, 32'h0);
        chk("hr req", 32'(imem_req), 32'h0);
        step(1, 0, 0, 0, 0, 0);
        chk("hr2 req", 32'(imem_req), 32'h1);
        chk("hr2 addr", imem_addr, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        chk("wr req", 32'(imem_req), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
